// File: rtl/npu_cube_add_csa_pipe.sv
// npu_cube_add_csa_pipe
// Level-4 carry-save compression stage of the NPU cube adder tree.
// Each lane compresses one (sum, carry, cc) triple with a row of 3:2
// counters and a top half adder. The result is registered behind a
// valid/ready handshake. The stage also provides a per-lane mask, a
// saturating accepted-beat counter and a synchronous clear.
// Optional build macro: NPU_CUBE_ADD_RESOLVE_EN adds out_res, which is
// out_sum + (out_cay << 3) resolved per lane.
module npu_cube_add_csa_pipe #(
  parameter int unsigned LANES = 4,
  parameter int unsigned IN_W  = 10,
  parameter int unsigned CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic [LANES-1:0]            lane_en,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*(IN_W+1)-1:0]   in_sum,
  input  logic [LANES*IN_W-1:0]       in_cay,
  input  logic [LANES*IN_W-1:0]       in_cc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*(IN_W+2)-1:0]   out_sum,
  output logic [LANES*IN_W-1:0]       out_cay,
  output logic [CNT_W-1:0]            beat_cnt
`ifdef NPU_CUBE_ADD_RESOLVE_EN
  ,
  output logic [LANES*(IN_W+4)-1:0]   out_res
`endif
);

  localparam int unsigned SW = IN_W + 2;
  localparam int unsigned RW = IN_W + 4;

  logic                      accept;
  logic [LANES*SW-1:0]       nxt_sum;
  logic [LANES*IN_W-1:0]     nxt_cay;
`ifdef NPU_CUBE_ADD_RESOLVE_EN
  logic [LANES*RW-1:0]       nxt_res;
`endif

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready & ~clr;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [IN_W:0]   s;
    logic [IN_W-1:0] a;
    logic [IN_W-1:0] c;
    logic [SW-1:0]   ps;
    logic [IN_W-1:0] pc;

    assign s = in_sum[k*(IN_W+1) +: IN_W+1];
    assign a = in_cay[k*IN_W +: IN_W];
    assign c = in_cc[k*IN_W +: IN_W];

    // The two low sum bits have no partner at their weight and pass straight through.
    assign ps[1:0] = s[1:0];

    for (genvar i = 0; i < IN_W - 1; i++) begin : g_fa
      assign ps[i+2] = s[i+2] ^ c[i] ^ a[i];
      assign pc[i]   = (s[i+2] & c[i]) | (s[i+2] & a[i]) | (c[i] & a[i]);
    end

    assign ps[IN_W+1] = c[IN_W-1] ^ a[IN_W-1];
    assign pc[IN_W-1] = c[IN_W-1] & a[IN_W-1];

    assign nxt_sum[k*SW +: SW]     = lane_en[k] ? ps : '0;
    assign nxt_cay[k*IN_W +: IN_W] = lane_en[k] ? pc : '0;

`ifdef NPU_CUBE_ADD_RESOLVE_EN
    // The carry vector sits three bit positions above the sum vector.
    assign nxt_res[k*RW +: RW] = RW'(nxt_sum[k*SW +: SW])
                               + (RW'(nxt_cay[k*IN_W +: IN_W]) << 3);
`endif
  end

  // Output register, handshake state and saturating beat counter; clr overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cay   <= '0;
      beat_cnt  <= '0;
`ifdef NPU_CUBE_ADD_RESOLVE_EN
      out_res   <= '0;
`endif
    end else if (clr) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cay   <= '0;
      beat_cnt  <= '0;
`ifdef NPU_CUBE_ADD_RESOLVE_EN
      out_res   <= '0;
`endif
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_sum   <= nxt_sum;
        out_cay   <= nxt_cay;
`ifdef NPU_CUBE_ADD_RESOLVE_EN
        out_res   <= nxt_res;
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept && (beat_cnt != '1)) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_npu_cube_add_csa_pipe.sv
// Self-checking bench for npu_cube_add_csa_pipe: directed vector table,
// backpressure / streaming / clear / saturation / reset sequences, and
// (with NPU_CUBE_ADD_RESOLVE_EN) a random out_res compare.
module tb_npu_cube_add_csa_pipe;

  localparam int L = 4;
  localparam int W = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic [L-1:0] lane_en = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [L*(W+1)-1:0] in_sum = '0;
  logic [L*W-1:0] in_cay = '0;
  logic [L*W-1:0] in_cc = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [L*(W+2)-1:0] out_sum;
  logic [L*W-1:0] out_cay;
  logic [15:0] beat_cnt;
`ifdef NPU_CUBE_ADD_RESOLVE_EN
  logic [L*(W+4)-1:0] out_res;
`endif

  // Small instance for counter saturation (CNT_W=4).
  logic s_in_valid = 1'b0;
  logic s_in_ready;
  logic s_out_valid;
  logic [4:0] s_out_sum;
  logic [2:0] s_out_cay;
  logic [3:0] s_beat_cnt;
`ifdef NPU_CUBE_ADD_RESOLVE_EN
  logic [6:0] s_out_res;
`endif

  always #5 clk = ~clk;

  npu_cube_add_csa_pipe #(.LANES(L), .IN_W(W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .lane_en(lane_en),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_cay(in_cay), .in_cc(in_cc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cay(out_cay), .beat_cnt(beat_cnt)
`ifdef NPU_CUBE_ADD_RESOLVE_EN
    , .out_res(out_res)
`endif
  );

  npu_cube_add_csa_pipe #(.LANES(1), .IN_W(3), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .lane_en(1'b1),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_sum(4'h0), .in_cay(3'h0), .in_cc(3'h0),
    .out_valid(s_out_valid), .out_ready(1'b1),
    .out_sum(s_out_sum), .out_cay(s_out_cay), .beat_cnt(s_beat_cnt)
`ifdef NPU_CUBE_ADD_RESOLVE_EN
    , .out_res(s_out_res)
`endif
  );

  typedef struct {
    logic [L-1:0]       en;
    logic [L*(W+1)-1:0] s;
    logic [L*W-1:0]     a;
    logic [L*W-1:0]     c;
    logic [L*(W+2)-1:0] es;
    logic [L*W-1:0]     ea;
  } vec_t;

  vec_t vec [6];
  int tests = 0;
  int fails = 0;
  logic [15:0] exp_cnt = '0;
  logic [L*(W+2)-1:0] held_sum;
  logic [L*W-1:0] held_cay;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [L-1:0] en, input logic [L*(W+1)-1:0] s,
                       input logic [L*W-1:0] a, input logic [L*W-1:0] c);
    lane_en = en;
    in_sum  = s;
    in_cay  = a;
    in_cc   = c;
  endtask

`ifdef NPU_CUBE_ADD_RESOLVE_EN
  function automatic logic [L*(W+4)-1:0] res_model(input logic [L-1:0] en,
      input logic [L*(W+1)-1:0] s, input logic [L*W-1:0] a, input logic [L*W-1:0] c);
    logic [L*(W+4)-1:0] r;
    r = '0;
    for (int k = 0; k < L; k++) begin
      if (en[k])
        r[k*(W+4) +: W+4] = 14'(s[k*(W+1) +: W+1]) + (14'(a[k*W +: W]) << 2)
                          + (14'(c[k*W +: W]) << 2);
    end
    return r;
  endfunction
`endif

  initial begin
    vec[0] = '{4'hF, {4{11'h7FF}}, {4{10'h3FF}}, {4{10'h3FF}}, {4{12'h7FF}}, {4{10'h3FF}}};
    vec[1] = '{4'hF, {11'h7FF, 11'h005, 11'h7FF, 11'h7FF},
               {10'h3FF, 10'h000, 10'h3FF, 10'h3FF}, {10'h3FF, 10'h000, 10'h3FF, 10'h3FF},
               {12'h7FF, 12'h005, 12'h7FF, 12'h7FF}, {10'h3FF, 10'h000, 10'h3FF, 10'h3FF}};
    vec[2] = '{4'hB, {11'h7FF, 11'h005, 11'h7FF, 11'h7FF},
               {10'h3FF, 10'h000, 10'h3FF, 10'h3FF}, {10'h3FF, 10'h000, 10'h3FF, 10'h3FF},
               {12'h7FF, 12'h000, 12'h7FF, 12'h7FF}, {10'h3FF, 10'h000, 10'h3FF, 10'h3FF}};
    vec[3] = '{4'hF, {4{11'h004}}, {4{10'h001}}, '0, '0, {4{10'h001}}};
    vec[4] = '{4'hF, '0, {4{10'h3FF}}, '0, {4{12'hFFC}}, '0};
    vec[5] = '{4'h5, {4{11'h003}}, {4{10'h155}}, {4{10'h2AA}},
               {12'h000, 12'hFFF, 12'h000, 12'hFFF}, '0};

    // Reset state
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_out_cay", 64'(out_cay), 64'd0);
    chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Directed vector table, one beat each
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      drive(vec[v].en, vec[v].s, vec[v].a, vec[v].c);
      in_valid = 1'b1;
      exp_cnt++;
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", v), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_sum", v), 64'(out_sum), 64'(vec[v].es));
      chk($sformatf("vec%0d_cay", v), 64'(out_cay), 64'(vec[v].ea));
      chk($sformatf("vec%0d_cnt", v), 64'(beat_cnt), 64'(exp_cnt));
    end

    // Drained with no new accept: valid drops, data held
    @(negedge clk);
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_sum_held", 64'(out_sum), 64'(vec[5].es));

    // Backpressure: load one beat then stall three cycles with a new beat offered
    drive(4'hF, {4{11'h7FF}}, {4{10'h3FF}}, {4{10'h3FF}});
    in_valid = 1'b1;
    exp_cnt++;
    @(negedge clk);
    out_ready = 1'b0;
    drive(4'hF, {4{11'h001}}, '0, '0);
    held_sum = out_sum;
    held_cay = out_cay;
    chk("bp_loaded_sum", 64'(out_sum), 64'(vec[0].es));
    for (int j = 0; j < 3; j++) begin
      #1;
      chk($sformatf("bp%0d_in_ready", j), 64'(in_ready), 64'd0);
      @(negedge clk);
      chk($sformatf("bp%0d_valid", j), 64'(out_valid), 64'd1);
      chk($sformatf("bp%0d_sum", j), 64'(out_sum), 64'(held_sum));
      chk($sformatf("bp%0d_cay", j), 64'(out_cay), 64'(held_cay));
      chk($sformatf("bp%0d_cnt", j), 64'(beat_cnt), 64'(exp_cnt));
    end

    // Release: five beats stream back-to-back, a=c=0 so out_sum equals s
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      logic [10:0] sv;
      sv = 11'(4 * j + 1);
      drive(4'hF, {4{sv}}, '0, '0);
      #1;
      chk($sformatf("st%0d_in_ready", j), 64'(in_ready), 64'd1);
      exp_cnt++;
      @(negedge clk);
      chk($sformatf("st%0d_valid", j), 64'(out_valid), 64'd1);
      chk($sformatf("st%0d_sum", j), 64'(out_sum), 64'({4{1'b0, sv}}));
      chk($sformatf("st%0d_cnt", j), 64'(beat_cnt), 64'(exp_cnt));
    end

    // clr with a beat offered and downstream ready: beat lost, state zeroed
    drive(4'hF, {4{11'h7FF}}, {4{10'h3FF}}, {4{10'h3FF}});
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    in_valid = 1'b0;
    exp_cnt = '0;
    chk("clr_valid", 64'(out_valid), 64'd0);
    chk("clr_cnt", 64'(beat_cnt), 64'd0);
    chk("clr_sum", 64'(out_sum), 64'd0);
    chk("clr_cay", 64'(out_cay), 64'd0);

    // Counter saturation on the CNT_W=4 instance
    s_in_valid = 1'b1;
    repeat (15) @(negedge clk);
    chk("sat_at15", 64'(s_beat_cnt), 64'hF);
    repeat (5) @(negedge clk);
    s_in_valid = 1'b0;
    chk("sat_at20", 64'(s_beat_cnt), 64'hF);

`ifdef NPU_CUBE_ADD_RESOLVE_EN
    // Resolved output: directed case then random stream
    drive(4'hF, {4{11'h004}}, {4{10'h001}}, '0);
    in_valid = 1'b1;
    @(negedge clk);
    chk("res_dir_sum", 64'(out_sum), 64'd0);
    chk("res_dir_cay", 64'(out_cay), 64'({4{10'h001}}));
    chk("res_dir_res", 64'(out_res), 64'({4{14'h008}}));
    for (int j = 0; j < 1000; j++) begin
      logic [L-1:0] en;
      logic [L*(W+1)-1:0] s;
      logic [L*W-1:0] a;
      logic [L*W-1:0] c;
      en = 4'($urandom);
      s  = {$urandom, $urandom};
      a  = {$urandom, $urandom};
      c  = {$urandom, $urandom};
      drive(en, s, a, c);
      @(negedge clk);
      chk($sformatf("res_rand%0d", j), 64'(out_res), 64'(res_model(en, s, a, c)));
    end
    in_valid = 1'b0;
`endif

    // Asynchronous reset in the middle of a transfer
    drive(4'hF, {4{11'h7FF}}, {4{10'h3FF}}, {4{10'h3FF}});
    in_valid = 1'b1;
    @(negedge clk);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_sum", 64'(out_sum), 64'd0);
    chk("mid_rst_cnt", 64'(beat_cnt), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
